mem_port_arbiter: RTL and testbench

Single-port arbiter for the 1024x32 block RAM, shared by three requesters: instruction fetch from the control unit, bit-serial data load/store from the serialiser, and a debug/loader port. Each cycle it grants at most one requester and drives the RAM enable, write mask, address and write data. It routes a one-cycle-later completion strobe back to the winner. It replaces the static `pc_addr_en` address mux and supports locked read-modify-write sequences for sub-word stores.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates the single port of the 1024x32 block RAM between three
//   requesters: instruction fetch (read-only), the bit-serial data path and
//   the debug/loader port. At most one grant per cycle. The winner drives the
//   RAM in the same cycle, and its rvalid strobe follows one cycle later.
//   A data access issued with data_lock=1 keeps the port for the data path
//   until a data access with data_lock=0, so sub-word read-modify-write
//   sequences cannot be interleaved with other requesters.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   fetch_req/addr -> fetch_gnt     fetch request, combinational grant
//   fetch_rvalid                    completion, one cycle after grant
//   data_req/lock/addr/wdata/we_mask -> data_gnt, data_rvalid
//   dbg_req/addr/wdata/we_mask      -> dbg_gnt,  dbg_rvalid
//   mem_en/addr/din/wr_mask         RAM command from the granted requester
//   mem_dout -> rdata               RAM read data, passed straight through
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_req,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic                    fetch_gnt,
  output logic                    fetch_rvalid,
  input  logic                    data_req,
  input  logic                    data_lock,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_we_mask,
  output logic                    data_gnt,
  output logic                    data_rvalid,
  input  logic                    dbg_req,
  input  logic [ADDR_WIDTH-1:0]   dbg_addr,
  input  logic [DATA_WIDTH-1:0]   dbg_wdata,
  input  logic [DATA_WIDTH/8-1:0] dbg_we_mask,
  output logic                    dbg_gnt,
  output logic                    dbg_rvalid,
  output logic                    mem_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  output logic [DATA_WIDTH/8-1:0] mem_wr_mask,
  input  logic [DATA_WIDTH-1:0]   mem_dout,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t     state_r;
  logic [3:0] starve_cnt_r;
  logic       fetch_rvalid_r;
  logic       data_rvalid_r;
  logic       dbg_rvalid_r;

  logic       fetch_gnt_s;
  logic       data_gnt_s;
  logic       dbg_gnt_s;
  logic       starved_s;

  assign starved_s = (starve_cnt_r == STARVE_MAX);

  // Grant selection: reset blocks everything, LOCKED admits only data,
  // otherwise starved fetch > dbg > data > fetch.
  always_comb begin
    fetch_gnt_s = 1'b0;
    data_gnt_s  = 1'b0;
    dbg_gnt_s   = 1'b0;
    if (rst) begin
      fetch_gnt_s = 1'b0;
    end else if (state_r == ST_LOCKED) begin
      data_gnt_s = data_req;
    end else if (fetch_req && starved_s) begin
      fetch_gnt_s = 1'b1;
    end else if (dbg_req) begin
      dbg_gnt_s = 1'b1;
    end else if (data_req) begin
      data_gnt_s = 1'b1;
    end else begin
      fetch_gnt_s = fetch_req;
    end
  end

  // RAM command mux; fetch is read-only so its mask and write data are zero.
  always_comb begin
    mem_addr    = {ADDR_WIDTH{1'b0}};
    mem_din     = {DATA_WIDTH{1'b0}};
    mem_wr_mask = {MASK_WIDTH{1'b0}};
    case ({dbg_gnt_s, data_gnt_s, fetch_gnt_s})
      3'b001: begin
        mem_addr = fetch_addr;
      end
      3'b010: begin
        mem_addr    = data_addr;
        mem_din     = data_wdata;
        mem_wr_mask = data_we_mask;
      end
      3'b100: begin
        mem_addr    = dbg_addr;
        mem_din     = dbg_wdata;
        mem_wr_mask = dbg_we_mask;
      end
      default: begin
        mem_addr    = {ADDR_WIDTH{1'b0}};
        mem_din     = {DATA_WIDTH{1'b0}};
        mem_wr_mask = {MASK_WIDTH{1'b0}};
      end
    endcase
  end

  // Lock state, fetch starvation counter and completion strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_OPEN;
      starve_cnt_r   <= 4'd0;
      fetch_rvalid_r <= 1'b0;
      data_rvalid_r  <= 1'b0;
      dbg_rvalid_r   <= 1'b0;
    end else begin
      fetch_rvalid_r <= fetch_gnt_s;
      data_rvalid_r  <= data_gnt_s;
      dbg_rvalid_r   <= dbg_gnt_s;

      case (state_r)
        ST_OPEN: begin
          if (data_gnt_s && data_lock) begin
            state_r <= ST_LOCKED;
          end else begin
            state_r <= ST_OPEN;
          end
        end
        ST_LOCKED: begin
          if (data_gnt_s && !data_lock) begin
            state_r <= ST_OPEN;
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r <= ST_OPEN;
        end
      endcase

      // The counter is frozen while locked so fetch keeps its place in line.
      if (state_r == ST_LOCKED) begin
        starve_cnt_r <= starve_cnt_r;
      end else if (!fetch_req || fetch_gnt_s) begin
        starve_cnt_r <= 4'd0;
      end else if (starve_cnt_r != STARVE_MAX) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  assign fetch_gnt = fetch_gnt_s;
  assign data_gnt  = data_gnt_s;
  assign dbg_gnt   = dbg_gnt_s;
  assign mem_en    = fetch_gnt_s | data_gnt_s | dbg_gnt_s;

  // A completion due in a reset cycle is dropped rather than delivered.
  assign fetch_rvalid = fetch_rvalid_r & ~rst;
  assign data_rvalid  = data_rvalid_r & ~rst;
  assign dbg_rvalid   = dbg_rvalid_r & ~rst;

  assign rdata = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt, fetch_rvalid;
  logic          data_req = 1'b0;
  logic          data_lock = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [3:0]    data_we_mask = '0;
  logic          data_gnt, data_rvalid;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic [3:0]    dbg_we_mask = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [3:0]    mem_wr_mask;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // RAM contents are stored XOR a per-address hash so the zero default of
  // 'bit' arrays stands for a non-trivial initial image.
  bit [31:0] ram    [0:1023];
  bit [31:0] shadow [0:1023];

  // Reference model state.
  bit        m_locked = 1'b0;
  int        m_wait = 0;
  logic [2:0]  exp_rv = 3'b000;
  bit          exp_rd_chk = 1'b0;
  logic [31:0] exp_rdata = '0;

  // Snapshot of outputs taken at the last checked cycle.
  logic [2:0]  s_gnt, s_rv;
  logic        s_en;
  logic [AW-1:0] s_addr;
  logic [3:0]  s_mask;
  logic [31:0] s_rdata;

  logic [2:0]  win [0:9];
  logic [31:0] w16;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
    .data_req(data_req), .data_lock(data_lock), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_we_mask(data_we_mask),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_we_mask(dbg_we_mask), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wr_mask(mem_wr_mask), .mem_dout(mem_dout), .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural synchronous RAM.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= ram[mem_addr] ^ hash(int'(mem_addr));
      ram[mem_addr] <= merge(ram[mem_addr] ^ hash(int'(mem_addr)), mem_din, mem_wr_mask)
                       ^ hash(int'(mem_addr));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected winner: 0 none, 1 fetch, 2 data, 3 dbg.
  function automatic int winner();
    if (rst) return 0;
    if (m_locked) return data_req ? 2 : 0;
    if (fetch_req && m_wait >= LIMIT) return 1;
    if (dbg_req) return 3;
    if (data_req) return 2;
    if (fetch_req) return 1;
    return 0;
  endfunction

  // One clock: check all outputs against the model, then advance the model.
  task automatic cycle();
    int w;
    logic [2:0]  g_exp;
    logic [AW-1:0] a_exp;
    logic [31:0] d_exp;
    logic [3:0]  m_exp;
    @(negedge clk);
    w = winner();
    g_exp = 3'b000; a_exp = '0; d_exp = '0; m_exp = 4'h0;
    case (w)
      1: begin g_exp = 3'b001; a_exp = fetch_addr; end
      2: begin g_exp = 3'b010; a_exp = data_addr; d_exp = data_wdata; m_exp = data_we_mask; end
      3: begin g_exp = 3'b100; a_exp = dbg_addr; d_exp = dbg_wdata; m_exp = dbg_we_mask; end
      default: ;
    endcase
    s_gnt = {dbg_gnt, data_gnt, fetch_gnt};
    s_rv = {dbg_rvalid, data_rvalid, fetch_rvalid};
    s_en = mem_en; s_addr = mem_addr; s_mask = mem_wr_mask; s_rdata = rdata;
    chk("gnt", 64'(s_gnt), 64'(g_exp));
    chk("mem_en", 64'(s_en), 64'(g_exp != 3'b000));
    chk("mem_addr", 64'(s_addr), 64'(a_exp));
    chk("mem_wr_mask", 64'(s_mask), 64'(m_exp));
    if (w != 1) chk("mem_din", 64'(mem_din), 64'(d_exp));
    chk("rvalid", 64'(s_rv), 64'(rst ? 3'b000 : exp_rv));
    if (!rst && exp_rd_chk) chk("rdata", 64'(s_rdata), 64'(exp_rdata));
    exp_rv = g_exp;
    exp_rd_chk = 1'b0;
    if (w != 0) begin
      if (m_exp == 4'h0) begin
        exp_rdata = shadow[a_exp] ^ hash(int'(a_exp));
        exp_rd_chk = 1'b1;
      end else begin
        shadow[a_exp] = merge(shadow[a_exp] ^ hash(int'(a_exp)), d_exp, m_exp) ^ hash(int'(a_exp));
      end
    end
    if (rst) begin
      m_locked = 1'b0;
      m_wait = 0;
    end else begin
      if (!m_locked) m_wait = (fetch_req && w != 1) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
      if (w == 2) m_locked = data_lock;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    fetch_req = 1'b0; data_req = 1'b0; dbg_req = 1'b0; data_lock = 1'b0;
    data_we_mask = 4'h0; dbg_we_mask = 4'h0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset gating, fetch read, fetch mask forced to zero.
    rst = 1'b1; fetch_req = 1'b1; fetch_addr = 10'h004; dbg_we_mask = 4'hF;
    cycle();
    chk("rst_gnt", 64'(s_gnt), 64'(3'b000));
    chk("rst_en", 64'(s_en), 64'(1'b0));
    chk("rst_rv", 64'(s_rv), 64'(3'b000));
    rst = 1'b0;
    cycle();
    chk("fetch_gnt", 64'(s_gnt), 64'(3'b001));
    chk("fetch_addr", 64'(s_addr), 64'(10'h004));
    chk("fetch_mask", 64'(s_mask), 64'(4'h0));
    fetch_req = 1'b0; dbg_we_mask = 4'h0;
    cycle();
    chk("fetch_rv", 64'(s_rv), 64'(3'b001));
    chk("fetch_rdata", 64'(s_rdata), 64'(hash(4)));

    // Starvation: all three requesting from reset.
    do_reset();
    fetch_req = 1'b1; fetch_addr = 10'h040;
    data_req = 1'b1; data_addr = 10'h101;
    dbg_req = 1'b1; dbg_addr = 10'h100;
    for (int i = 0; i < 10; i++) begin
      cycle();
      win[i] = s_gnt;
    end
    for (int i = 0; i < 10; i++) chk("starve_seq", 64'(win[i]), 64'((i == 8) ? 3'b001 : 3'b100));
    idle_all();
    cycle();

    // Partial write then read-back.
    do_reset();
    data_req = 1'b1; data_addr = 10'h010; data_wdata = 32'hDEADBEEF; data_we_mask = 4'b0011;
    cycle();
    chk("wr_gnt", 64'(s_gnt), 64'(3'b010));
    chk("wr_mask", 64'(s_mask), 64'(4'b0011));
    data_we_mask = 4'h0;
    cycle();
    chk("wr_rv", 64'(s_rv), 64'(3'b010));
    data_req = 1'b0;
    cycle();
    w16 = hash(16);
    chk("rd_rv", 64'(s_rv), 64'(3'b010));
    chk("rd_merge", 64'(s_rdata), 64'({w16[31:16], 16'hBEEF}));

    // Locked read-modify-write holds off dbg.
    do_reset();
    data_req = 1'b1; data_lock = 1'b1; data_addr = 10'h020; data_we_mask = 4'h0;
    cycle();
    chk("lock_rd", 64'(s_gnt), 64'(3'b010));
    data_req = 1'b0; dbg_req = 1'b1; dbg_addr = 10'h030;
    cycle();
    chk("lock_blk", 64'(s_gnt), 64'(3'b000));
    data_req = 1'b1; data_lock = 1'b0; data_wdata = $urandom; data_we_mask = 4'hF;
    cycle();
    chk("lock_wr", 64'(s_gnt), 64'(3'b010));
    data_req = 1'b0; data_we_mask = 4'h0;
    cycle();
    chk("unlock_dbg", 64'(s_gnt), 64'(3'b100));
    idle_all();
    cycle();

    // Reset while locked drops the in-flight completion and reopens.
    do_reset();
    data_req = 1'b1; data_lock = 1'b1; data_addr = 10'h020;
    cycle();
    chk("lk2_gnt", 64'(s_gnt), 64'(3'b010));
    rst = 1'b1;
    cycle();
    chk("lk2_rst_rv", 64'(s_rv), 64'(3'b000));
    chk("lk2_rst_gnt", 64'(s_gnt), 64'(3'b000));
    rst = 1'b0; data_req = 1'b0; data_lock = 1'b0; dbg_req = 1'b1; dbg_addr = 10'h031;
    cycle();
    chk("lk2_dbg", 64'(s_gnt), 64'(3'b100));
    chk("lk2_no_rv", 64'(s_rv), 64'(3'b000));
    dbg_req = 1'b0;
    cycle();
    chk("lk2_dbg_rv", 64'(s_rv), 64'(3'b100));

    // Randomized traffic; requesters hold their request until granted.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (!fetch_req || s_gnt[0]) begin
        fetch_req = ($urandom_range(0, 3) != 0);
        fetch_addr = 10'($urandom_range(0, 15));
      end
      if (!data_req || s_gnt[1]) begin
        data_req = ($urandom_range(0, 3) != 0);
        data_lock = ($urandom_range(0, 3) == 0);
        data_addr = 10'($urandom_range(0, 15));
        data_wdata = $urandom;
        data_we_mask = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      if (!dbg_req || s_gnt[2]) begin
        dbg_req = ($urandom_range(0, 1) != 0);
        dbg_addr = 10'($urandom_range(0, 15));
        dbg_wdata = $urandom;
        dbg_we_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_all();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
